// File: rtl/psk_pkg.sv
// Shared definitions for the PSK Tx frame arbiter: legal transmitter modes,
// arbiter FSM state encoding and the mode sanitizer used at grant time.
package psk_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS  = 3'd1,
    ST_ABORT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

  // Anything that is not one of the three one-hot modes falls back to BPSK,
  // so the modulator never sees an undefined MODE_CTRL code.
  function automatic logic [3:0] mode_sanitize(input logic [3:0] mode);
    logic [3:0] legal;
    case (mode)
      MODE_BPSK, MODE_QPSK, MODE_MIX: legal = mode;
      default:                        legal = MODE_BPSK;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/psk_tx_frame_arbiter_if.sv
// AXI-Stream byte bus with a per-frame mode request. The mode field is an
// input request on the source side and carries the active MODE_CTRL on the
// transmitter side.
interface psk_tx_frame_arbiter_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tuser;
  logic              tready;
  logic [3:0]        mode;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    output mode,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    input  mode,
    output tready
  );

endinterface

// File: rtl/psk_rr_arb2.sv
// Two-way round-robin picker. rr_last names the source that won the previous
// grant; on a tie the other source wins. Purely combinational.
module psk_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt_onehot,
  output logic       rr_next
);

  // Pick a winner and report who should be remembered as last winner
  always_comb begin
    gnt_onehot = 2'b00;
    rr_next    = rr_last;
    case (req)
      2'b01: begin
        gnt_onehot = 2'b01;
        rr_next    = 1'b0;
      end
      2'b10: begin
        gnt_onehot = 2'b10;
        rr_next    = 1'b1;
      end
      2'b11: begin
        if (rr_last) begin
          gnt_onehot = 2'b01;
          rr_next    = 1'b0;
        end else begin
          gnt_onehot = 2'b10;
          rr_next    = 1'b1;
        end
      end
      default: begin
        gnt_onehot = 2'b00;
        rr_next    = rr_last;
      end
    endcase
  end

endmodule

// File: rtl/psk_tx_frame_arbiter.sv
// Frame-atomic arbiter sharing the PSK transmitter byte stream between two
// AXI-Stream sources. Ownership and MODE_CTRL change only between frames;
// an inter-frame gap is forced and a stalled frame is terminated with an
// abort beat so neither source can lock the modulator.
module psk_tx_frame_arbiter
  import psk_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic                    clk_16M384,
  input  logic                    rst_16M384,
  psk_tx_frame_arbiter_if.slave   s0,
  psk_tx_frame_arbiter_if.slave   s1,
  psk_tx_frame_arbiter_if.master  m,
  output logic [3:0]              MODE_CTRL,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic                    abort_pulse
);

  localparam logic [15:0] STALL_LIM = 16'(STALL_TIMEOUT - 1);
  localparam logic [15:0] STALL_MAX = 16'hFFFF;
  localparam logic [7:0]  GAP_LIM   = 8'(GAP_CYCLES - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              rr_last;
  logic [15:0]       stall_cnt;
  logic [7:0]        gap_cnt;
  logic              last_seen;

  logic [1:0]        arb_gnt;
  logic              arb_rr_next;

  // Owner-side view of the stream, selected by the registered grant
  logic              sel;
  logic [DATA_W-1:0] own_tdata;
  logic              own_tvalid;
  logic              own_tlast;
  logic              own_tuser;
  logic              own_hs;

  // Combinational outputs of the FSM
  logic [DATA_W-1:0] m_tdata_c;
  logic              m_tvalid_c;
  logic              m_tlast_c;
  logic              m_tuser_c;
  logic              s0_tready_c;
  logic              s1_tready_c;
  logic              abort_c;

  psk_rr_arb2 u_rr_arb2 (
    .req        ({s1.tvalid, s0.tvalid}),
    .rr_last    (rr_last),
    .gnt_onehot (arb_gnt),
    .rr_next    (arb_rr_next)
  );

  assign sel        = grant[1];
  assign own_tdata  = sel ? s1.tdata  : s0.tdata;
  assign own_tvalid = sel ? s1.tvalid : s0.tvalid;
  assign own_tlast  = sel ? s1.tlast  : s0.tlast;
  assign own_tuser  = sel ? s1.tuser  : s0.tuser;
  assign own_hs     = (state == ST_PASS) && own_tvalid && m.tready;

  // State register
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_nxt = ST_PASS;
        end
      end
      ST_PASS: begin
        if (own_hs) begin
          if (own_tlast) begin
            state_nxt = ST_GAP;
          end
        end else if (stall_cnt == STALL_LIM) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // A tlast already offered by the owner means the frame tail exists
        // upstream; no flush is needed to resynchronise the source.
        if (m.tready) begin
          if (last_seen || (own_tvalid && own_tlast)) begin
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (own_tvalid && own_tlast) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LIM) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: zero-latency pass-through, abort beat, flush sink
  always_comb begin
    m_tdata_c   = '0;
    m_tvalid_c  = 1'b0;
    m_tlast_c   = 1'b0;
    m_tuser_c   = 1'b0;
    s0_tready_c = 1'b0;
    s1_tready_c = 1'b0;
    abort_c     = 1'b0;
    case (state)
      ST_PASS: begin
        m_tdata_c   = own_tdata;
        m_tvalid_c  = own_tvalid;
        m_tlast_c   = own_tlast;
        m_tuser_c   = own_tuser;
        s0_tready_c = ~sel & m.tready;
        s1_tready_c =  sel & m.tready;
      end
      ST_ABORT: begin
        m_tvalid_c = 1'b1;
        m_tlast_c  = 1'b1;
        m_tuser_c  = 1'b1;
        abort_c    = m.tready;
      end
      ST_FLUSH: begin
        s0_tready_c = ~sel;
        s1_tready_c =  sel;
      end
      default: begin
        m_tvalid_c = 1'b0;
      end
    endcase
  end

  assign m.tdata     = m_tdata_c;
  assign m.tvalid    = m_tvalid_c;
  assign m.tlast     = m_tlast_c;
  assign m.tuser     = m_tuser_c;
  assign m.mode      = MODE_CTRL;
  assign s0.tready   = s0_tready_c;
  assign s1.tready   = s1_tready_c;
  assign abort_pulse = abort_c;
  assign busy        = (state != ST_IDLE);

  // Grant, mode and round-robin history: set at frame start, grant dropped at gap entry
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      grant     <= 2'b00;
      MODE_CTRL <= MODE_BPSK;
      rr_last   <= 1'b1;
    end else if ((state == ST_IDLE) && (arb_gnt != 2'b00)) begin
      grant     <= arb_gnt;
      MODE_CTRL <= mode_sanitize(arb_gnt[1] ? s1.mode : s0.mode);
      rr_last   <= arb_rr_next;
    end else if ((state != ST_GAP) && (state_nxt == ST_GAP)) begin
      grant     <= 2'b00;
    end
  end

  // Stall watchdog: cleared by every owner handshake, saturating otherwise
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      stall_cnt <= '0;
    end else if (state != ST_PASS) begin
      stall_cnt <= '0;
    end else if (own_hs) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Remember an offered but not yet accepted tlast from the owner
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      last_seen <= 1'b0;
    end else if (state == ST_IDLE) begin
      last_seen <= 1'b0;
    end else if (((state == ST_PASS) || (state == ST_ABORT)) && own_tvalid && own_tlast && !own_hs) begin
      last_seen <= 1'b1;
    end
  end

  // Inter-frame gap counter
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      gap_cnt <= '0;
    end else if (state != ST_GAP) begin
      gap_cnt <= '0;
    end else if (gap_cnt == GAP_LIM) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_psk_tx_frame_arbiter.sv
// Directed bench for psk_tx_frame_arbiter: one table-driven frame plus
// hand-written sequences for arbitration, mode latching, abort/flush,
// back-pressure and asynchronous reset.
module tb_psk_tx_frame_arbiter;
  import psk_pkg::*;

  localparam int GAP = 16;
  localparam int TMO = 8;

  logic       clk_16M384 = 1'b0;
  logic       rst_16M384 = 1'b1;
  logic [3:0] MODE_CTRL;
  logic [1:0] grant;
  logic       busy;
  logic       abort_pulse;

  int n_cmp = 0;
  int n_err = 0;

  psk_tx_frame_arbiter_if #(.DATA_W(8)) s0_if ();
  psk_tx_frame_arbiter_if #(.DATA_W(8)) s1_if ();
  psk_tx_frame_arbiter_if #(.DATA_W(8)) m_if ();

  psk_tx_frame_arbiter #(
    .DATA_W        (8),
    .GAP_CYCLES    (GAP),
    .STALL_TIMEOUT (TMO)
  ) dut (
    .clk_16M384  (clk_16M384),
    .rst_16M384  (rst_16M384),
    .s0          (s0_if),
    .s1          (s1_if),
    .m           (m_if),
    .MODE_CTRL   (MODE_CTRL),
    .grant       (grant),
    .busy        (busy),
    .abort_pulse (abort_pulse)
  );

  always #5 clk_16M384 = ~clk_16M384;

  typedef struct {
    logic       s0v;
    logic [7:0] s0d;
    logic       s0l;
    logic [3:0] s0m;
    logic       rdy;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
    logic [1:0] e_g;
    logic [3:0] e_mode;
    logic       e_busy;
    logic       e_s0r;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    s0_if.tvalid = 1'b0; s0_if.tdata = 8'h00; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0; s0_if.mode = 4'h0;
    s1_if.tvalid = 1'b0; s1_if.tdata = 8'h00; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0; s1_if.mode = 4'h0;
    m_if.tready  = 1'b1;
  endtask

  task automatic do_reset();
    clr();
    rst_16M384 = 1'b1;
    @(negedge clk_16M384);
    @(negedge clk_16M384);
    rst_16M384 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk_16M384);
      k++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, b1, nfr, ndone, idx, ab, src;
    logic [1:0] prev_g;
    logic [3:0] cur_m;
    logic [1:0] exp_g [4];
    logic [3:0] exp_m [4];
    logic [7:0] rx[$];

    // ---------------- reset state ----------------
    clr();
    @(negedge clk_16M384);
    @(negedge clk_16M384);
    chk("rst grant", {30'd0, grant}, 32'd0);
    chk("rst mode", {28'd0, MODE_CTRL}, 32'h1);
    chk("rst m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst s0_tready", {31'd0, s0_if.tready}, 32'd0);
    chk("rst s1_tready", {31'd0, s1_if.tready}, 32'd0);
    chk("rst abort", {31'd0, abort_pulse}, 32'd0);
    rst_16M384 = 1'b0;
    @(negedge clk_16M384);

    // ---------------- table: single source 4-byte frame ----------------
    tbl.push_back('{1'b1, 8'h11, 1'b0, 4'h2, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'h1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 4'h2, 1'b1, 1'b1, 8'h11, 1'b0, 2'b01, 4'h2, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 8'h12, 1'b0, 4'h2, 1'b1, 1'b1, 8'h12, 1'b0, 2'b01, 4'h2, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 8'h13, 1'b0, 4'h2, 1'b1, 1'b1, 8'h13, 1'b0, 2'b01, 4'h2, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 8'h14, 1'b1, 4'h2, 1'b1, 1'b1, 8'h14, 1'b1, 2'b01, 4'h2, 1'b1, 1'b1});
    for (int g = 0; g < GAP; g++)
      tbl.push_back('{1'b0, 8'h00, 1'b0, 4'h2, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'h2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 4'h2, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'h2, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      s0_if.tvalid = tbl[i].s0v;
      s0_if.tdata  = tbl[i].s0d;
      s0_if.tlast  = tbl[i].s0l;
      s0_if.mode   = tbl[i].s0m;
      m_if.tready  = tbl[i].rdy;
      #2;
      chk($sformatf("t1[%0d] m_tvalid", i), {31'd0, m_if.tvalid}, {31'd0, tbl[i].e_mv});
      if (tbl[i].e_mv) begin
        chk($sformatf("t1[%0d] m_tdata", i), {24'd0, m_if.tdata}, {24'd0, tbl[i].e_md});
        chk($sformatf("t1[%0d] m_tlast", i), {31'd0, m_if.tlast}, {31'd0, tbl[i].e_ml});
      end
      chk($sformatf("t1[%0d] grant", i), {30'd0, grant}, {30'd0, tbl[i].e_g});
      chk($sformatf("t1[%0d] mode", i), {28'd0, MODE_CTRL}, {28'd0, tbl[i].e_mode});
      chk($sformatf("t1[%0d] busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("t1[%0d] s0_tready", i), {31'd0, s0_if.tready}, {31'd0, tbl[i].e_s0r});
      @(negedge clk_16M384);
    end

    // ---------------- both sources, 2-byte frames, alternation ----------------
    do_reset();
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_m[0] = 4'h2;  exp_m[1] = 4'h4;  exp_m[2] = 4'h1;  exp_m[3] = 4'h4;
    s0_if.mode = MODE_QPSK; s1_if.mode = MODE_MIX;
    s0_if.tvalid = 1'b1; s1_if.tvalid = 1'b1; m_if.tready = 1'b1;
    b0 = 0; b1 = 0; nfr = 0; ndone = 0; prev_g = 2'b00; cur_m = 4'h0; src = 0;
    for (int c = 0; c < 200 && ndone < 4; c++) begin
      s0_if.tdata = 8'(8'h20 + b0); s0_if.tlast = (b0 == 1);
      s1_if.tdata = 8'(8'h30 + b1); s1_if.tlast = (b1 == 1);
      #2;
      if (grant != 2'b00 && prev_g == 2'b00 && nfr < 4) begin
        chk($sformatf("t2 grant f%0d", nfr), {30'd0, grant}, {30'd0, exp_g[nfr]});
        chk($sformatf("t2 mode f%0d", nfr), {28'd0, MODE_CTRL}, {28'd0, exp_m[nfr]});
        cur_m = exp_m[nfr];
        src = exp_g[nfr][1] ? 1 : 0;
        nfr++;
      end
      if (m_if.tvalid) begin
        chk("t2 mode hold", {28'd0, MODE_CTRL}, {28'd0, cur_m});
        chk("t2 data", {24'd0, m_if.tdata}, (src == 1) ? 32'h30 + b1 : 32'h20 + b0);
      end
      if (m_if.tvalid && m_if.tready && m_if.tlast) ndone++;
      if (s0_if.tready) begin
        if (b0 == 1) s0_if.mode = MODE_BPSK;
        b0 = 1 - b0;
      end
      if (s1_if.tready) b1 = 1 - b1;
      prev_g = grant;
      @(negedge clk_16M384);
    end
    chk("t2 frames done", ndone, 4);
    clr();
    wait_idle("t2 idle");

    // ---------------- s1 mode change mid-frame ----------------
    s1_if.mode = MODE_MIX; s1_if.tvalid = 1'b1; s1_if.tdata = 8'h41; s1_if.tlast = 1'b0;
    #2;
    chk("t3 idle grant", {30'd0, grant}, 32'd0);
    @(negedge clk_16M384);
    for (int b = 0; b < 3; b++) begin
      s1_if.tdata = 8'(8'h41 + b);
      s1_if.tlast = (b == 2);
      #2;
      chk($sformatf("t3 data b%0d", b), {24'd0, m_if.tdata}, 32'h41 + b);
      chk($sformatf("t3 mode b%0d", b), {28'd0, MODE_CTRL}, 32'h4);
      chk($sformatf("t3 grant b%0d", b), {30'd0, grant}, 32'h2);
      chk($sformatf("t3 s1_tready b%0d", b), {31'd0, s1_if.tready}, 32'd1);
      @(negedge clk_16M384);
      s1_if.mode = MODE_BPSK;
    end
    s1_if.tvalid = 1'b0;
    #2;
    chk("t3 gap busy", {31'd0, busy}, 32'd1);
    chk("t3 gap grant", {30'd0, grant}, 32'd0);
    chk("t3 gap mode", {28'd0, MODE_CTRL}, 32'h4);
    @(negedge clk_16M384);
    wait_idle("t3 idle");

    // ---------------- single-beat frame with illegal mode ----------------
    s0_if.mode = 4'b0011; s0_if.tvalid = 1'b1; s0_if.tdata = 8'h5A; s0_if.tlast = 1'b1;
    @(negedge clk_16M384);
    #2;
    chk("t3b m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("t3b m_tlast", {31'd0, m_if.tlast}, 32'd1);
    chk("t3b mode", {28'd0, MODE_CTRL}, 32'h1);
    chk("t3b grant", {30'd0, grant}, 32'h1);
    @(negedge clk_16M384);
    s0_if.tvalid = 1'b0;
    #2;
    chk("t3b gap grant", {30'd0, grant}, 32'd0);
    chk("t3b gap busy", {31'd0, busy}, 32'd1);
    chk("t3b gap m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    @(negedge clk_16M384);
    wait_idle("t3b idle");

    // ---------------- stall abort and flush ----------------
    s0_if.mode = MODE_QPSK; s0_if.tvalid = 1'b1; s0_if.tdata = 8'hA1; s0_if.tlast = 1'b0;
    @(negedge clk_16M384);
    for (int b = 0; b < 2; b++) begin
      s0_if.tdata = 8'(8'hA1 + b);
      #2;
      chk($sformatf("t4 data b%0d", b), {24'd0, m_if.tdata}, 32'hA1 + b);
      @(negedge clk_16M384);
    end
    s0_if.tvalid = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      #2;
      chk($sformatf("t4 stall%0d m_tvalid", k), {31'd0, m_if.tvalid}, 32'd0);
      chk($sformatf("t4 stall%0d abort", k), {31'd0, abort_pulse}, 32'd0);
      @(negedge clk_16M384);
    end
    m_if.tready = 1'b0; s0_if.tvalid = 1'b1; s0_if.tdata = 8'hA3; s0_if.tlast = 1'b0;
    #2;
    chk("t4 abort m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("t4 abort m_tdata", {24'd0, m_if.tdata}, 32'd0);
    chk("t4 abort m_tlast", {31'd0, m_if.tlast}, 32'd1);
    chk("t4 abort m_tuser", {31'd0, m_if.tuser}, 32'd1);
    chk("t4 abort held pulse", {31'd0, abort_pulse}, 32'd0);
    chk("t4 abort s0_tready", {31'd0, s0_if.tready}, 32'd0);
    @(negedge clk_16M384);
    m_if.tready = 1'b1;
    #2;
    chk("t4 abort hs m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("t4 abort hs pulse", {31'd0, abort_pulse}, 32'd1);
    chk("t4 abort hs s0_tready", {31'd0, s0_if.tready}, 32'd0);
    @(negedge clk_16M384);
    for (int b = 2; b < 5; b++) begin
      s0_if.tdata = 8'(8'hA1 + b);
      s0_if.tlast = (b == 4);
      #2;
      chk($sformatf("t4 flush%0d m_tvalid", b), {31'd0, m_if.tvalid}, 32'd0);
      chk($sformatf("t4 flush%0d s0_tready", b), {31'd0, s0_if.tready}, 32'd1);
      chk($sformatf("t4 flush%0d abort", b), {31'd0, abort_pulse}, 32'd0);
      @(negedge clk_16M384);
    end
    s0_if.tvalid = 1'b0;
    #2;
    chk("t4 gap grant", {30'd0, grant}, 32'd0);
    chk("t4 gap busy", {31'd0, busy}, 32'd1);
    chk("t4 gap s0_tready", {31'd0, s0_if.tready}, 32'd0);
    @(negedge clk_16M384);
    wait_idle("t4 idle");

    // ---------------- back-pressure 1010 on a 6-byte frame ----------------
    s1_if.mode = MODE_QPSK; idx = 0; ab = 0; rx.delete();
    for (int c = 0; c < 40 && idx < 6; c++) begin
      s1_if.tvalid = 1'b1;
      s1_if.tdata  = 8'(8'h60 + idx);
      s1_if.tlast  = (idx == 5);
      s1_if.tuser  = (idx == 0);
      m_if.tready  = (c % 2 == 0);
      #2;
      if (abort_pulse) ab++;
      if (m_if.tvalid) chk($sformatf("t5 tuser i%0d", idx), {31'd0, m_if.tuser}, (idx == 0) ? 32'd1 : 32'd0);
      if (m_if.tvalid && m_if.tready) rx.push_back(m_if.tdata);
      if (s1_if.tready && s1_if.tvalid) idx++;
      @(negedge clk_16M384);
    end
    s1_if.tvalid = 1'b0; s1_if.tuser = 1'b0; m_if.tready = 1'b1;
    chk("t5 rx count", rx.size(), 6);
    foreach (rx[i]) chk($sformatf("t5 rx%0d", i), {24'd0, rx[i]}, 32'h60 + i);
    chk("t5 no abort", ab, 0);
    #2;
    chk("t5 gap grant", {30'd0, grant}, 32'd0);
    @(negedge clk_16M384);
    wait_idle("t5 idle");

    // ---------------- asynchronous reset during beat 3 ----------------
    s0_if.mode = MODE_MIX; s0_if.tvalid = 1'b1; s0_if.tdata = 8'hB1; s0_if.tlast = 1'b0;
    @(negedge clk_16M384);
    for (int b = 0; b < 2; b++) begin
      s0_if.tdata = 8'(8'hB1 + b);
      @(negedge clk_16M384);
    end
    s0_if.tdata = 8'hB3;
    #2;
    chk("t6 beat3 m_tdata", {24'd0, m_if.tdata}, 32'hB3);
    chk("t6 beat3 mode", {28'd0, MODE_CTRL}, 32'h4);
    rst_16M384 = 1'b1;
    #1;
    chk("t6 async grant", {30'd0, grant}, 32'd0);
    chk("t6 async mode", {28'd0, MODE_CTRL}, 32'h1);
    chk("t6 async m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("t6 async busy", {31'd0, busy}, 32'd0);
    chk("t6 async s0_tready", {31'd0, s0_if.tready}, 32'd0);
    @(negedge clk_16M384);
    rst_16M384 = 1'b0;
    s0_if.mode = MODE_QPSK; s0_if.tdata = 8'hC0; s0_if.tlast = 1'b1; s0_if.tvalid = 1'b1;
    s1_if.mode = MODE_MIX;  s1_if.tdata = 8'hD0; s1_if.tlast = 1'b1; s1_if.tvalid = 1'b1;
    #2;
    chk("t6 idle grant", {30'd0, grant}, 32'd0);
    @(negedge clk_16M384);
    #2;
    chk("t6 post grant", {30'd0, grant}, 32'h1);
    chk("t6 post mode", {28'd0, MODE_CTRL}, 32'h2);
    chk("t6 post m_tdata", {24'd0, m_if.tdata}, 32'hC0);
    chk("t6 post m_tlast", {31'd0, m_if.tlast}, 32'd1);
    @(negedge clk_16M384);
    clr();
    wait_idle("t6 idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psk_tx_frame_arbiter.md
Name: psk_tx_frame_arbiter

Overview:
- Frame-atomic arbiter that shares the Tx byte-stream input (data_tdata/tlast/tuser/tvalid) of the PSK transmitter between two AXI-Stream sources.
- Typical sources are host DMA data and an on-chip test-pattern generator.
- Drives the transmitter's MODE_CTRL per frame, so BPSK, QPSK or MIX can change only on frame boundaries.
- Enforces an inter-frame gap and aborts stalled frames, so one requester can never lock the modulator.

Parameters:
- DATA_W, 8, width of tdata on all stream ports.
- GAP_CYCLES, 16, idle clk_16M384 cycles forced between frames (1..255).
- STALL_TIMEOUT, 4096, consecutive cycles without a handshake in mid-frame before abort (2..65535).

Ports:
- clk_16M384, in, 1, sole clock.
- rst_16M384, in, 1, asynchronous active-high reset.
- s0_tdata, in, DATA_W, source 0 data.
- s0_tvalid, in, 1, source 0 valid.
- s0_tlast, in, 1, source 0 end of frame.
- s0_tuser, in, 1, source 0 sideband, passed through.
- s0_tready, out, 1, source 0 ready.
- s0_mode, in, 4, requested mode for source 0's next frame.
- s1_tdata, s1_tvalid, s1_tlast, s1_tuser, s1_tready, s1_mode: same as source 0, for source 1.
- m_tdata, out, DATA_W, data to Tx.
- m_tvalid, out, 1, valid to Tx.
- m_tlast, out, 1, end of frame to Tx.
- m_tuser, out, 1, sideband to Tx (1 on an abort beat).
- m_tready, in, 1, Tx ready.
- MODE_CTRL, out, 4, mode to Tx and Rx; registered.
- grant, out, 2, one-hot owner of the current frame (00 when none).
- busy, out, 1, high in any state other than IDLE.
- abort_pulse, out, 1, one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values: state=IDLE, grant=00, MODE_CTRL=4'b0001 (BPSK), rr_last=1 (source 0 wins the first tie), m_tvalid=0, all s*_tready=0, abort_pulse=0, counters=0.
- The FSM has five states: IDLE, PASS, ABORT, FLUSH, GAP.
- IDLE:
  - A request is sX_tvalid=1.
  - If one source requests, grant it. If both request, grant the source that is not rr_last.
  - In the same edge: latch sX_mode into MODE_CTRL, update rr_last, go to PASS.
  - A mode value other than 0001/0010/0100 latches 0001.
- PASS (datapath is combinational, zero latency):
  - m_* = granted s_*.
  - Granted sX_tready = m_tready. The other source's tready = 0.
  - A handshake with m_tlast=1 moves to GAP and clears grant.
  - stall_cnt resets on every handshake and increments otherwise. It reaching STALL_TIMEOUT-1 moves to ABORT.
- ABORT:
  - Drive m_tvalid=1, m_tdata=0, m_tlast=1, m_tuser=1. Hold until m_tready.
  - On the handshake: pulse abort_pulse. If the aborted source had already presented tlast, go to GAP; otherwise go to FLUSH.
  - sX_tready=0 throughout ABORT.
- FLUSH:
  - Aborted source's tready=1; its beats are discarded. m_tvalid=0.
  - A beat with tlast=1 moves to GAP.
  - FLUSH has no timeout; a dead source keeps the block in FLUSH until reset.
- GAP:
  - m_tvalid=0, all tready=0.
  - gap_cnt counts 0..GAP_CYCLES-1, then the FSM goes to IDLE.
  - Arbitration happens only in IDLE, so there is at least 1 IDLE cycle after the gap.
- MODE_CTRL changes only on the IDLE->PASS edge and never mid-frame.
- A single-beat frame (tvalid=tlast=1 on the first beat) is legal: PASS lasts 1 cycle.
- A source may drop tvalid mid-frame. Grant is held; only the stall counter advances.
- A source's mode input is sampled only at grant; later changes are ignored until its next grant.
- Asynchronous reset mid-frame returns to reset values immediately. No tlast is emitted; the downstream Tx is reset by the same reset.
- Width rules:
  - stall_cnt is 16 bits, saturating.
  - gap_cnt is 8 bits.

Decomposition:
- Shared package psk_pkg holds MODE_BPSK=4'b0001, MODE_QPSK=4'b0010, MODE_MIX=4'b0100, the state enum, and a function mode_sanitize(mode) -> legal mode.
- One sub-module: psk_rr_arb2. It is the 2-way round-robin picker (inputs req[1:0] and rr_last; outputs gnt_onehot and the next rr_last). It is combinational and sits beside the FSM in this block.

Test Plan:
- Only s0 sends a 4-byte frame 0x11..0x14 with s0_mode=0010 and m_tready=1 -> grant=01 and MODE_CTRL=0010 from the first beat; m_* mirrors s0 with 0 latency; tlast on 0x14; then 16 GAP cycles with m_tvalid=0.
- s0 and s1 both request continuously with 2-byte frames -> grant alternates 01,10,01,...; s0 is granted first after reset; MODE_CTRL follows each frame's source mode only at frame start.
- s1 sends a frame with s1_mode=0100; s1_mode changes to 0001 mid-frame -> MODE_CTRL stays 0100 until the frame's tlast is accepted.
- s0 stalls after 2 beats (tvalid=0) with STALL_TIMEOUT=8 -> after 8 stall cycles an abort beat is emitted (m_tdata=0, m_tlast=1, m_tuser=1) and abort_pulse=1 for 1 cycle; s0's remaining 3 beats are accepted with m_tvalid=0 until its tlast; then GAP.
- Back-pressure: m_tready toggles 1010 during a 6-byte frame -> every byte is delivered exactly once, in order; stall_cnt never reaches the timeout.
- Assert rst_16M384 asynchronously during beat 3 of a frame -> grant=00, MODE_CTRL=0001 and m_tvalid=0 with no clock edge; after release, the next request is arbitrated normally from IDLE.
